count_sched: RTL and testbench
==============================

// Module: count_sched
// PURPOSE
//   Shares one 4-bit up-counter between NREQ requesters that each need a timed interval.
//   A round-robin arbiter grants the counter to one requester at a time.
//   The counter then runs from 0 up to that requester's programmed limit.
//   On completion the block pulses done to the owner and releases the counter.
//   Sits between interval-timing clients and the shared free-running counter datapath.
// PARAMETERS
//   NREQ  4  number of requesters (>=2)
//   CW    4  counter width in bits; limits range 0..2**CW-1
// PORTS
//   clk      in   1          rising-edge clock
//   reset_n  in   1          asynchronous active-low reset
//   req      in   NREQ       level request per client; held until done or abandoned
//   limit_in in   NREQ*CW    per-client terminal count; slice i = limit_in[i*CW +: CW]
//   gnt      out  NREQ       one-hot registered grant; owner of the counter
//   done     out  NREQ       one-cycle completion pulse to the owner
//   count    out  CW         current counter value
//   busy     out  1          high whenever state != IDLE
// BEHAVIOUR
//   Reset
//   - Asynchronous: state=IDLE, gnt=0, done=0, count=0, busy=0, rr_ptr=0.
//   - reset_n asserted mid-RUN: counter released immediately; no done is issued.
//   States: IDLE, RUN, DONE.
//   - IDLE, req!=0: winner is the first set req searching from rr_ptr upward, mod NREQ.
//     At the edge: latch idx and limit slice, set gnt[idx]=1, count=0, go RUN.
//   - IDLE, req==0: hold; all outputs 0.
//   - RUN, req[idx]==1, count!=lim: count <= count+1.
//   - RUN, count==lim: at the edge go DONE; gnt<=0, done[idx]<=1, count<=0.
//   - RUN, req[idx]==0 (abandon): takes priority over the terminal check.
//     At the edge go IDLE; gnt<=0, count<=0, no done, rr_ptr<=idx+1 mod NREQ.
//   - DONE: at the edge done<=0, rr_ptr<=idx+1 mod NREQ, go IDLE.
//   Timing
//   - gnt is high for exactly lim+1 cycles, with count 0..lim.
//   - done is high 1 cycle, then 1 IDLE cycle follows.
//   - Back-to-back grants are therefore spaced by lim+3 cycles.
//   - limit 0: one RUN cycle with count=0, then done.
//   Rules
//   - The limit is latched at grant; limit_in changes during RUN are ignored.
//   - count never wraps: lim <= 2**CW-1, so the count stops at lim (15 -> 16 RUN cycles).
//   - A requester that re-asserts req during DONE/IDLE competes normally.
//   - rr_ptr has already moved past it, so the others win first if requesting.
//   - Simultaneous requests: exactly one gnt bit is ever set; gnt and done are never both set.
//   - req bits of non-owners are ignored while busy.
// TESTING
//   - Reset: assert reset_n=0 mid-RUN -> gnt=0, done=0, count=0, busy=0 asynchronously.
//     After release the block returns to IDLE.
//   - Single client: req=4'b0010, limit1=3 -> gnt=0010 for 4 cycles, count 0,1,2,3.
//     Then done=0010 for 1 cycle, then IDLE.
//   - Round-robin: req=4'b1111 held, all limits=0 -> grant order 0,1,2,3,0.
//     Each grant is 1 cycle, spaced 3 cycles apart.
//   - Limit extremes: limit=0 -> 1 RUN cycle; limit=15 -> count reaches 15.
//     No wrap; done on the cycle after count=15.
//   - Abandon: client 2, limit=10; drop req[2] at count=4 -> next cycle gnt=0, no done, IDLE.
//     rr_ptr=3, so a pending req[3] wins over req[0].
//   - Limit change: alter limit_in slice during RUN -> the original latched limit governs done timing.

Source files
------------

// File: rtl/count_sched.sv
// count_sched: shares one CW-bit up-counter between NREQ requesters.
// A round-robin arbiter grants the counter. The owner's counter runs 0..limit.
// When it finishes, done pulses to the owner and the counter is released.
module count_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   limit_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [CW-1:0]        count,
  output logic                 busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   lim;
  logic [IW-1:0]   rr_ptr;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [CW-1:0]   win_lim;
  logic [IW-1:0]   nxt_ptr;

  // Round-robin pick: first set req at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    int unsigned j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr) + k) % NREQ;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  // Winner's terminal count, and the pointer position just past the current owner
  always_comb begin
    win_lim = limit_in[32'(win_idx)*CW +: CW];
    nxt_ptr = (idx == IW'(NREQ-1)) ? '0 : idx + IW'(1);
  end

  // Arbitration/counting FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      lim    <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      done   <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            idx   <= win_idx;
            lim   <= win_lim;
            gnt   <= NREQ'(1) << win_idx;
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!req[idx]) begin
            // Owner abandoned: release without a done pulse
            gnt    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            rr_ptr <= nxt_ptr;
            state  <= S_IDLE;
          end else if (count == lim) begin
            gnt   <= '0;
            done  <= NREQ'(1) << idx;
            count <= '0;
            state <= S_DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_DONE: begin
          done   <= '0;
          busy   <= 1'b0;
          rr_ptr <= nxt_ptr;
          state  <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= '0;
          count <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: vector table plus directed multi-cycle sequences.
module tb_count_sched;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] limit_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  count;
  logic        busy;

  int checks;
  int failures;

  count_sched #(.NREQ(4), .CW(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .limit_in (limit_in),
    .gnt      (gnt),
    .done     (done),
    .count    (count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] lim;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  count;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic [3:0] c, input logic b);
    chk({tag, ".gnt"},   32'(gnt),   32'(g));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants checked every cycle out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ((gnt & done) != 4'b0 || !$onehot0(gnt) || !$onehot0(done) ||
          busy !== ((gnt != 4'b0) || (done != 4'b0))) begin
        failures++;
        $display("FAIL invariant: gnt=%b done=%b busy=%b at %0t", gnt, done, busy, $time);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    req      = 4'b0;
    limit_in = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 4'b0, 4'b0, 4'd0, 1'b0);
    reset_n = 1'b1;
    tick();
    expect_out("idle_after_reset", 4'b0, 4'b0, 4'd0, 1'b0);

    // Round-robin with zero limits, then client 1 with limit 3
    vq.push_back('{4'b1111, 16'h0000, 4'b0001, 4'b0000, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0001, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0});
    vq.push_back('{4'b1111, 16'h0000, 4'b0010, 4'b0000, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0010, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0});
    vq.push_back('{4'b1111, 16'h0000, 4'b0100, 4'b0000, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0100, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0});
    vq.push_back('{4'b1111, 16'h0000, 4'b1000, 4'b0000, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b1000, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0});
    vq.push_back('{4'b1111, 16'h0000, 4'b0001, 4'b0000, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0001, 4'd0, 1'b1});
    vq.push_back('{4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0});
    vq.push_back('{4'b0010, 16'h0030, 4'b0010, 4'b0000, 4'd0, 1'b1});
    vq.push_back('{4'b0010, 16'h0030, 4'b0010, 4'b0000, 4'd1, 1'b1});
    vq.push_back('{4'b0010, 16'h0030, 4'b0010, 4'b0000, 4'd2, 1'b1});
    vq.push_back('{4'b0010, 16'h0030, 4'b0010, 4'b0000, 4'd3, 1'b1});
    vq.push_back('{4'b0010, 16'h0030, 4'b0000, 4'b0010, 4'd0, 1'b1});
    vq.push_back('{4'b0000, 16'h0030, 4'b0000, 4'b0000, 4'd0, 1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      req      = vq[i].req;
      limit_in = vq[i].lim;
      tick();
      expect_out($sformatf("vec%0d", i), vq[i].gnt, vq[i].done, vq[i].count, vq[i].busy);
    end

    // Limit 15: count climbs to 15 without wrapping, done on the next cycle
    req      = 4'b0001;
    limit_in = 16'h000F;
    for (int c = 0; c < 16; c++) begin
      tick();
      expect_out($sformatf("lim15_c%0d", c), 4'b0001, 4'b0000, 4'(c), 1'b1);
    end
    tick();
    expect_out("lim15_done", 4'b0000, 4'b0001, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("lim15_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Limit change mid-run: latched limit 5 governs, not the new value 1
    req      = 4'b0010;
    limit_in = 16'h0050;
    tick();
    expect_out("lchg_grant", 4'b0010, 4'b0000, 4'd0, 1'b1);
    limit_in = 16'h0010;
    for (int c = 1; c <= 5; c++) begin
      tick();
      expect_out($sformatf("lchg_c%0d", c), 4'b0010, 4'b0000, 4'(c), 1'b1);
    end
    tick();
    expect_out("lchg_done", 4'b0000, 4'b0010, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("lchg_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Abandon: client 2 drops at count 4; pointer moves to 3 so req[3] beats req[0]
    req      = 4'b0100;
    limit_in = 16'h0A00;
    tick();
    expect_out("abn_grant", 4'b0100, 4'b0000, 4'd0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      expect_out($sformatf("abn_c%0d", c), 4'b0100, 4'b0000, 4'(c), 1'b1);
    end
    req      = 4'b1001;
    limit_in = 16'hFA00;
    tick();
    expect_out("abn_release", 4'b0000, 4'b0000, 4'd0, 1'b0);
    tick();
    expect_out("abn_next", 4'b1000, 4'b0000, 4'd0, 1'b1);
    tick();
    expect_out("abn_next_c1", 4'b1000, 4'b0000, 4'd1, 1'b1);
    tick();
    expect_out("abn_next_c2", 4'b1000, 4'b0000, 4'd2, 1'b1);

    // Asynchronous reset mid-run clears everything before the next edge
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 4'b0000, 4'd0, 1'b0);
    req = 4'b0000;
    tick();
    #1;
    reset_n = 1'b1;
    tick();
    expect_out("post_rst_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    // Pointer returned to 0, so client 0 beats client 2
    req      = 4'b0101;
    limit_in = 16'h0000;
    tick();
    expect_out("post_rst_grant", 4'b0001, 4'b0000, 4'd0, 1'b1);
    tick();
    expect_out("post_rst_done", 4'b0000, 4'b0001, 4'd0, 1'b1);
    req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
